buffer_sender: RTL and testbench
================================

// Module: buffer_sender
// PURPOSE
// - Sits directly downstream of the debug packer that flattens PC, instruction, control, register-file and
//   hazard-unit state into one N-bit word; streams that word byte by byte to the UART transmitter.
// - Takes a snapshot on a send request, so the word may keep changing during the transfer.
// - Handshakes with the UART TX once per byte and signals completion to the debug controller.
// PARAMETERS
// - N        1208  width of buffer_envio in bits; must be a multiple of 8 (N/8 = 151 bytes by default)
// - NB_BYTE  8     width of one transmitted byte
// PORTS
// - clk           in   1   system clock; all state updates on its rising edge
// - reset_n       in   1   asynchronous, active-low reset
// - start         in   1   send request from the debug controller; sampled only in IDLE
// - buffer_envio  in   N   packed debug word (PC in [31:0], instruction in [63:32], ..., hazard signals in [N-1:N-56])
// - tx_done       in   1   one-cycle pulse from the UART TX when the current byte has been fully shifted out
// - tx_start      out  1   one-cycle pulse telling the UART TX to send tx_data
// - tx_data       out  8   byte to transmit; stable from the tx_start cycle until tx_done
// - busy          out  1   high from the cycle after start is accepted until DONE is left
// - done          out  1   one-cycle pulse when the last byte's tx_done has been received
// BEHAVIOUR
// - Clock and reset: one clock, clk; reset_n is asynchronous and active-low.
// - Reset (asynchronous, reset_n=0): state=IDLE, idx=0, snapshot=0, tx_start=0, tx_data=8'h00, busy=0,
//   done=0. Deassertion takes effect on the next clk edge.
// - All outputs are registered; there is no combinational path from an input to an output.
// - FSM states: IDLE, SEND, WAIT, DONE.
// - IDLE:
//   - start=1 -> snapshot<=buffer_envio, idx<=0, busy<=1, go to SEND.
//   - Otherwise stay in IDLE.
// - SEND (lasts exactly 1 cycle):
//   - tx_start<=1, tx_data<=snapshot[8*idx +: 8], go to WAIT.
//   - tx_start returns to 0 on the following cycle.
// - WAIT:
//   - Hold tx_data.
//   - On tx_done: if idx==LAST, go to DONE; else idx<=idx+1 and go to SEND.
//   - With no tx_done, wait indefinitely (no timeout).
// - DONE (1 cycle): done<=1, busy<=0, go to IDLE.
// - Byte order: LSB first. Byte 0 = bits [7:0]; byte N/8-1 = bits [N-1:N-8]. Bits within a byte are
//   handled by the UART.
// - Byte index: idx is $clog2(N/8+1) bits wide. LAST = N/8-1, or N/8 with the CONFIGURATION option on.
// - Per-byte cadence: tx_start pulses are at least 2 cycles apart. There is 1 cycle from tx_done to the
//   next tx_start.
// - Boundary conditions:
//   - start while busy: ignored. No restart and no re-snapshot.
//   - start held high continuously: after DONE->IDLE a new transfer begins on the next cycle.
//   - tx_done outside WAIT (IDLE, SEND, DONE): ignored. It does not advance idx.
//   - tx_done in the same cycle that WAIT is entered (that is, the SEND cycle): ignored.
//   - buffer_envio changing during a transfer: no effect on the bytes sent.
//   - reset_n asserted mid-transfer: everything returns to reset values immediately. Remaining bytes are
//     dropped and done is not pulsed.
// CONFIGURATION
// - Macro BUFFER_SENDER_CHECKSUM_EN.
// - Defined: after byte N/8-1, one extra byte is sent: the XOR of all N/8 payload bytes, computed
//   incrementally. It is cleared at start acceptance and accumulated in SEND. The frame is N/8+1 bytes and
//   done pulses after the checksum's tx_done.
// - Undefined: the frame is exactly N/8 bytes and no checksum logic is synthesized.
// TESTING
// - Reset: hold reset_n=0 mid-transfer (idx=40) -> tx_start=0, busy=0, done=0 at once; after release,
//   state is IDLE and no tx_start appears without start.
// - Basic frame: N=1208, buffer_envio[31:0]=32'h0040_0010, [63:32]=32'h2008_0005, start pulse, tx_done
//   pulsed 5 cycles after each tx_start -> 151 tx_start pulses; first bytes 10,00,40,00,05,00,08,20;
//   one done pulse after the 151st tx_done.
// - Snapshot: buffer_envio changed to all-ones one cycle after start -> every transmitted byte still
//   equals the original snapshot.
// - Ignored events: start pulsed at byte 20, spurious tx_done during SEND and while IDLE -> byte count
//   stays 151, order unchanged, no second frame.
// - Checksum (macro defined): N=16, buffer_envio=16'h3CA5 -> bytes A5, 3C, then 99; done after the 3rd
//   tx_done. Macro undefined -> bytes A5, 3C only.
// - Back-to-back: start held high for 2 frames with N=16 -> pattern of 2 frames, done pulsed twice,
//   busy low for exactly 1 cycle between frames.

Source files
------------

// File: rtl/buffer_sender_if.sv
// Bus between buffer_sender, its debug controller (start/busy/done/word) and the UART TX (tx_*).
// The master modport is the sender side; the slave modport drives the sender's inputs.
interface buffer_sender_if #(
    parameter int N       = 1208,
    parameter int NB_BYTE = 8
);
    logic               start;
    logic [N-1:0]       buffer_envio;
    logic               tx_done;
    logic               tx_start;
    logic [NB_BYTE-1:0] tx_data;
    logic               busy;
    logic               done;

    modport master (
        input  start, buffer_envio, tx_done,
        output tx_start, tx_data, busy, done
    );

    modport slave (
        output start, buffer_envio, tx_done,
        input  tx_start, tx_data, busy, done
    );
endinterface

// File: rtl/buffer_sender.sv
// Snapshots an N-bit debug word on start and streams it LSB byte first to a UART TX, one handshake per byte.
// Optional macro BUFFER_SENDER_CHECKSUM_EN appends an XOR checksum byte after the payload.
module buffer_sender #(
    parameter int N       = 1208,
    parameter int NB_BYTE = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    buffer_sender_if.master bus
);
    localparam int NBYTES = N / NB_BYTE;
`ifdef BUFFER_SENDER_CHECKSUM_EN
    localparam int FRAME = NBYTES + 1;
`else
    localparam int FRAME = NBYTES;
`endif
    localparam int IDX_W = $clog2(NBYTES + 1);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(FRAME - 1);

    typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [N-1:0]       snap_q, snap_d;
    logic               tx_start_q, tx_start_d;
    logic [NB_BYTE-1:0] tx_data_q, tx_data_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [NB_BYTE-1:0] pay_byte;
    int                 pay_idx;
`ifdef BUFFER_SENDER_CHECKSUM_EN
    logic [NB_BYTE-1:0] csum_q, csum_d;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            snap_q     <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef BUFFER_SENDER_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            snap_q     <= snap_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef BUFFER_SENDER_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = SEND;
            SEND:    state_d = WAIT;
            WAIT:    if (bus.tx_done) state_d = (idx_q == LAST) ? DONE : SEND;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The checksum index lies past the payload, so clamp it to keep the part-select in range.
    always_comb begin
        pay_idx  = (int'(idx_q) < NBYTES) ? int'(idx_q) : 0;
        pay_byte = snap_q[NB_BYTE*pay_idx +: NB_BYTE];
    end

    always_comb begin
        idx_d      = idx_q;
        snap_d     = snap_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
`ifdef BUFFER_SENDER_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    snap_d = bus.buffer_envio;
                    idx_d  = '0;
                    busy_d = 1'b1;
`ifdef BUFFER_SENDER_CHECKSUM_EN
                    csum_d = '0;
`endif
                end
            end
            SEND: begin
                tx_start_d = 1'b1;
`ifdef BUFFER_SENDER_CHECKSUM_EN
                if (idx_q == IDX_W'(NBYTES)) begin
                    tx_data_d = csum_q;
                end else begin
                    tx_data_d = pay_byte;
                    csum_d    = csum_q ^ pay_byte;
                end
`else
                tx_data_d = pay_byte;
`endif
            end
            WAIT: begin
                if (bus.tx_done && (idx_q != LAST)) idx_d = idx_q + IDX_W'(1);
            end
            DONE: begin
                done_d = 1'b1;
                busy_d = 1'b0;
            end
            default: ;
        endcase
    end

    assign bus.tx_start = tx_start_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_buffer_sender.sv
// Randomized bench for buffer_sender: a 1208-bit and a 16-bit instance with UART TX responders,
// checked against expected byte frames built directly from the snapshot word.
module tb_buffer_sender;
    localparam int NB = 1208;
    localparam int NS = 16;
    localparam int BB = NB / 8;
    localparam int BS = NS / 8;
`ifdef BUFFER_SENDER_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    buffer_sender_if #(.N(NB), .NB_BYTE(8)) bus_big ();
    buffer_sender_if #(.N(NS), .NB_BYTE(8)) bus_small ();

    buffer_sender #(.N(NB), .NB_BYTE(8)) u_big   (.clk(clk), .reset_n(reset_n), .bus(bus_big));
    buffer_sender #(.N(NS), .NB_BYTE(8)) u_small (.clk(clk), .reset_n(reset_n), .bus(bus_small));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    // UART responders/monitors: tx_done 5 cycles after each tx_start, optionally held a 2nd cycle.
    logic       resp_big = 1'b0, inj_big = 1'b0, resp_small = 1'b0, inj_small = 1'b0;
    logic [7:0] q_big[$];
    logic [7:0] q_small[$];
    int starts_big = 0, dones_big = 0, cnt_big = 0, stretch_big = -1;
    int starts_small = 0, dones_small = 0, cnt_small = 0;
    bit hold_big = 0, prev_big = 0, prev_small = 0;
    int cadence_err = 0;

    assign bus_big.tx_done   = resp_big | inj_big;
    assign bus_small.tx_done = resp_small | inj_small;

    always @(negedge clk) begin
        if (hold_big) begin
            resp_big = 1'b1;
            hold_big = 0;
        end else begin
            resp_big = 1'b0;
            if (cnt_big > 0) begin
                cnt_big--;
                if (cnt_big == 0) begin
                    resp_big = 1'b1;
                    hold_big = (starts_big == stretch_big);
                end
            end
        end
        if (bus_big.tx_start === 1'b1) begin
            q_big.push_back(bus_big.tx_data);
            starts_big++;
            cnt_big = 5;
            if (prev_big) cadence_err++;
        end
        prev_big = (bus_big.tx_start === 1'b1);
        if (bus_big.done === 1'b1) dones_big++;
    end

    always @(negedge clk) begin
        resp_small = 1'b0;
        if (cnt_small > 0) begin
            cnt_small--;
            if (cnt_small == 0) resp_small = 1'b1;
        end
        if (bus_small.tx_start === 1'b1) begin
            q_small.push_back(bus_small.tx_data);
            starts_small++;
            cnt_small = 5;
            if (prev_small) cadence_err++;
        end
        prev_small = (bus_small.tx_start === 1'b1);
        if (bus_small.done === 1'b1) dones_small++;
    end

    // Reference: byte i is bits [8i+7:8i] of the snapshot; optional trailer is the XOR of all bytes.
    task automatic cmp_frame(input string tag, input logic [7:0] got[$], input logic [NB-1:0] data,
                             input int nbytes, input int base);
        logic [7:0] x;
        logic [7:0] e;
        x = 8'h00;
        for (int i = 0; i < nbytes; i++) begin
            e = data[8*i +: 8];
            x = x ^ e;
            check($sformatf("%s_byte%0d", tag, i), {24'h0, got[base+i]}, {24'h0, e});
        end
        if (CS == 1) check($sformatf("%s_csum", tag), {24'h0, got[base+nbytes]}, {24'h0, x});
    endtask

    logic [NB-1:0] wbuf, wbuf2;
    logic [NB-1:0] sbuf;
    logic [7:0]    first8[8];
    bit            pulsed;
    int            nd, low, phase, s0;

    initial begin
        first8 = '{8'h10, 8'h00, 8'h40, 8'h00, 8'h05, 8'h00, 8'h08, 8'h20};
        reset_n = 1'b0;
        bus_big.start = 1'b0;   bus_big.buffer_envio = '0;
        bus_small.start = 1'b0; bus_small.buffer_envio = '0;
        repeat (3) tick;
        check("rst_tx_start", {31'h0, bus_big.tx_start}, 32'h0);
        check("rst_tx_data", {24'h0, bus_big.tx_data}, 32'h0);
        check("rst_busy", {31'h0, bus_big.busy}, 32'h0);
        check("rst_done", {31'h0, bus_big.done}, 32'h0);
        check("rst_small_busy", {31'h0, bus_small.busy}, 32'h0);
        reset_n = 1'b1;
        repeat (3) tick;

        // Spurious tx_done while idle must not start anything.
        inj_big = 1'b1; inj_small = 1'b1;
        tick;
        inj_big = 1'b0; inj_small = 1'b0;
        repeat (10) tick;
        check("idle_txdone_starts", starts_big + starts_small, 0);

        // Basic frame.
        for (int i = 0; i < BB; i++) wbuf[8*i +: 8] = 8'($urandom_range(0, 255));
        wbuf[31:0]  = 32'h0040_0010;
        wbuf[63:32] = 32'h2008_0005;
        bus_big.start = 1'b1; bus_big.buffer_envio = wbuf;
        tick;
        bus_big.start = 1'b0;
        check("busy_after_start", {31'h0, bus_big.busy}, 32'h1);
        for (int c = 0; c < 5000 && dones_big == 0; c++) tick;
        repeat (20) tick;
        check("f1_dones", dones_big, 1);
        check("f1_count", q_big.size(), BB + CS);
        check("f1_busy_end", {31'h0, bus_big.busy}, 32'h0);
        for (int i = 0; i < 8; i++) check($sformatf("f1_first%0d", i), {24'h0, q_big[i]}, {24'h0, first8[i]});
        cmp_frame("f1", q_big, wbuf, BB, 0);

        // Snapshot plus ignored start / tx_done in SEND.
        q_big.delete(); dones_big = 0; starts_big = 0; stretch_big = 30; pulsed = 0;
        for (int i = 0; i < BB; i++) wbuf2[8*i +: 8] = 8'($urandom_range(0, 255));
        bus_big.start = 1'b1; bus_big.buffer_envio = wbuf2;
        tick;
        bus_big.start = 1'b0; bus_big.buffer_envio = '1; inj_big = 1'b1;
        tick;
        inj_big = 1'b0;
        for (int c = 0; c < 5000 && dones_big == 0; c++) begin
            if (starts_big == 20 && !pulsed) begin
                bus_big.start = 1'b1;
                pulsed = 1;
            end else begin
                bus_big.start = 1'b0;
            end
            tick;
        end
        bus_big.start = 1'b0; stretch_big = -1;
        repeat (30) tick;
        check("f2_dones", dones_big, 1);
        check("f2_count", q_big.size(), BB + CS);
        cmp_frame("f2", q_big, wbuf2, BB, 0);

        // Reset mid-transfer at byte index 40.
        q_big.delete(); dones_big = 0; starts_big = 0;
        bus_big.buffer_envio = wbuf;
        bus_big.start = 1'b1;
        tick;
        bus_big.start = 1'b0;
        for (int c = 0; c < 2000 && starts_big < 41; c++) tick;
        check("rm_reached_idx40", starts_big, 41);
        reset_n = 1'b0;
        #1;
        check("rm_tx_start", {31'h0, bus_big.tx_start}, 32'h0);
        check("rm_busy", {31'h0, bus_big.busy}, 32'h0);
        check("rm_done", {31'h0, bus_big.done}, 32'h0);
        repeat (3) tick;
        reset_n = 1'b1;
        s0 = starts_big;
        repeat (40) tick;
        check("rm_no_tx_start", starts_big, s0);
        check("rm_no_done", dones_big, 0);

        // Small word, checksum case.
        sbuf = '0; sbuf[15:0] = 16'h3CA5;
        bus_small.buffer_envio = 16'h3CA5;
        bus_small.start = 1'b1;
        tick;
        bus_small.start = 1'b0;
        for (int c = 0; c < 500 && dones_small == 0; c++) tick;
        repeat (10) tick;
        check("cs_dones", dones_small, 1);
        check("cs_count", q_small.size(), BS + CS);
        check("cs_b0", {24'h0, q_small[0]}, 32'hA5);
        check("cs_b1", {24'h0, q_small[1]}, 32'h3C);
`ifdef BUFFER_SENDER_CHECKSUM_EN
        check("cs_b2", {24'h0, q_small[2]}, 32'h99);
`endif

        // Back-to-back with start held high.
        q_small.delete(); dones_small = 0; nd = 0; low = 0; phase = 0;
        sbuf = '0; sbuf[15:0] = 16'($urandom_range(0, 65535));
        bus_small.buffer_envio = sbuf[15:0];
        bus_small.start = 1'b1;
        for (int c = 0; c < 500 && nd < 2; c++) begin
            tick;
            if (bus_small.done === 1'b1) begin
                nd++;
                if (nd == 1) phase = 1;
                if (nd == 2) bus_small.start = 1'b0;
            end
            if (phase == 1) begin
                if (bus_small.busy === 1'b0) low++;
                else phase = 2;
            end
        end
        bus_small.start = 1'b0;
        repeat (20) tick;
        check("b2b_dones", dones_small, 2);
        check("b2b_count", q_small.size(), 2 * (BS + CS));
        check("b2b_busy_low", low, 1);
        cmp_frame("b2b_f0", q_small, sbuf, BS, 0);
        cmp_frame("b2b_f1", q_small, sbuf, BS, BS + CS);

        check("cadence", cadence_err, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
